// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexes a packed hex value onto one 7-segment decoder
// with frame-boundary double buffering and optional leading-zero blanking.
module hex_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  output logic                    x3_o,
  output logic                    x2_o,
  output logic                    x1_o,
  output logic                    x0_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    ack_o,
  output logic                    frame_start_o
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic pending_q, pending_d, ack_q, ack_d;
  logic [3:0] nib_q, nib_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic slot_end, frame_end;
  function automatic logic blank(input logic [DW-1:0] v, input logic [IW-1:0] k);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) z = 1'b0;
    return BLANK_LEADING != 0 && k != '0 && z;
  endfunction
  always_comb begin
    slot_end  = cnt_q == CW'(PRESCALE - 1);
    frame_end = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = !slot_end ? idx_q : frame_end ? '0 : idx_q + 1'b1;
    // A Load on the boundary edge commits directly, overriding any older shadow value
    disp_d    = !frame_end ? disp_q : load_i ? value_i : pending_q ? shadow_q : disp_q;
    shadow_d  = (load_i && !frame_end) ? value_i : shadow_q;
    pending_d = !frame_end && (load_i || pending_q);
    ack_d     = frame_end && (load_i || pending_q);
    nib_d     = slot_end ? disp_d[4*idx_d +: 4] : nib_q;
    en_d      = (cnt_d == '0 || blank(disp_d, idx_d)) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      nib_q     <= '0;
      en_q      <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      nib_q     <= nib_d;
      en_q      <= en_d;
    end
  end
  assign {x3_o, x2_o, x1_o, x0_o} = nib_q;
  assign digit_en_o    = en_q;
  assign ack_o         = ack_q;
  assign frame_start_o = cnt_q == '0 && idx_q == '0;
endmodule
